// File: rtl/mixer_pkg.sv
// rtl/mixer_pkg.sv - sizing helpers, saturation and channel-slice functions for the N-channel mixer
package mixer_pkg;

  typedef struct packed {
    logic [63:0] value;
    logic        clip;
  } sat_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int unity_gain(input int gain_w);
    return 1 << (gain_w - 1);
  endfunction

  // Wide enough that NUM_CH full-scale products can never overflow the accumulator.
  function automatic int sum_width(input int size, input int num_ch);
    return size + 1 + clog2(num_ch);
  endfunction

  function automatic int ch_lsb(input int ch, input int w);
    return ch * w;
  endfunction

  function automatic int ch_msb(input int ch, input int w);
    return ch * w + w - 1;
  endfunction

  function automatic sat_t saturate(input logic signed [63:0] x, input int size);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t r;
    hi = (64'sd1 <<< (size - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (size - 1));
    r.value = x;
    r.clip  = 1'b0;
    if (x > hi) begin
      r.value = hi;
      r.clip  = 1'b1;
    end else if (x < lo) begin
      r.value = lo;
      r.clip  = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mixer_gain_mult.sv
// rtl/mixer_gain_mult.sv - one channel's stereo gain stage: multiply, floor shift by GAIN_W-1, mute
module mixer_gain_mult
  import mixer_pkg::*;
#(
  parameter int SIZE   = 24,
  parameter int GAIN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [SIZE-1:0]   sample_left,
  input  logic [SIZE-1:0]   sample_right,
  input  logic [GAIN_W-1:0] gain,
  input  logic              mute,
  output logic [SIZE:0]     prod_left,
  output logic [SIZE:0]     prod_right
);

  localparam int PW = SIZE + GAIN_W + 1;

  // Gain is unsigned, so it is zero-extended before the signed multiply; the slice is an arithmetic shift.
  function automatic logic [SIZE:0] scale(input logic [SIZE-1:0] x, input logic [GAIN_W-1:0] g);
    logic signed [PW-1:0] p;
    p = $signed({{(GAIN_W+1){x[SIZE-1]}}, x}) * $signed({{(SIZE+1){1'b0}}, g});
    return p[GAIN_W-1 +: SIZE+1];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_left  <= '0;
      prod_right <= '0;
    end else if (en) begin
      prod_left  <= mute ? '0 : scale(sample_left, gain);
      prod_right <= mute ? '0 : scale(sample_right, gain);
    end
  end

endmodule

// File: rtl/audio_mixer_nch.sv
// rtl/audio_mixer_nch.sv - 3-stage N-channel stereo mixer with gain, mute, saturation and valid/ready
// Optional peak-hold meters are built when MIXER_PEAK_HOLD_EN is defined.
module audio_mixer_nch
  import mixer_pkg::*;
#(
  parameter int SIZE   = 24,
  parameter int NUM_CH = 4,
  parameter int GAIN_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [NUM_CH*SIZE-1:0]   audio_left_in,
  input  logic [NUM_CH*SIZE-1:0]   audio_right_in,
  input  logic [NUM_CH-1:0]        mute_in,
  input  logic [NUM_CH*GAIN_W-1:0] gain_in,
  input  logic                     gain_load,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [SIZE-1:0]          audio_mixed_left_out,
  output logic [SIZE-1:0]          audio_mixed_right_out,
  output logic                     clip_left_out,
  output logic                     clip_right_out
`ifdef MIXER_PEAK_HOLD_EN
  ,
  input  logic                     peak_clear,
  output logic [SIZE-2:0]          peak_left_out,
  output logic [SIZE-2:0]          peak_right_out
`endif
);

  localparam int SUM_W = sum_width(SIZE, NUM_CH);
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(GAIN_W));

  logic              en;
  logic              v1, v2, v3;
  logic [GAIN_W-1:0] gain_q [NUM_CH];
  logic [SIZE:0]     p_left [NUM_CH];
  logic [SIZE:0]     p_right [NUM_CH];
  logic [SUM_W-1:0]  sum_l_d, sum_r_d, sum_l_q, sum_r_q;

  assign en      = !m_valid || m_ready;
  assign s_ready = en;
  assign m_valid = v3;

  // Gains update independently of the pipeline enable; S1 samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) gain_q[k] <= UNITY;
    end else if (gain_load) begin
      for (int k = 0; k < NUM_CH; k++) gain_q[k] <= gain_in[ch_lsb(k, GAIN_W) +: GAIN_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (en) begin
      v1 <= s_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    mixer_gain_mult #(.SIZE(SIZE), .GAIN_W(GAIN_W)) u_mult (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .sample_left  (audio_left_in[ch_lsb(k, SIZE) +: SIZE]),
      .sample_right (audio_right_in[ch_lsb(k, SIZE) +: SIZE]),
      .gain         (gain_q[k]),
      .mute         (mute_in[k]),
      .prod_left    (p_left[k]),
      .prod_right   (p_right[k])
    );
  end

  always_comb begin
    sum_l_d = '0;
    sum_r_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum_l_d = sum_l_d + {{(SUM_W-SIZE-1){p_left[k][SIZE]}}, p_left[k]};
      sum_r_d = sum_r_d + {{(SUM_W-SIZE-1){p_right[k][SIZE]}}, p_right[k]};
    end
  end

  function automatic logic [SIZE:0] sat_pack(input logic [SUM_W-1:0] s);
    sat_t r;
    r = saturate({{(64-SUM_W){s[SUM_W-1]}}, s}, SIZE);
    return {r.clip, r.value[SIZE-1:0]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_l_q               <= '0;
      sum_r_q               <= '0;
      audio_mixed_left_out  <= '0;
      audio_mixed_right_out <= '0;
      clip_left_out         <= 1'b0;
      clip_right_out        <= 1'b0;
    end else if (en) begin
      sum_l_q <= sum_l_d;
      sum_r_q <= sum_r_d;
      {clip_left_out, audio_mixed_left_out}   <= sat_pack(sum_l_q);
      {clip_right_out, audio_mixed_right_out} <= sat_pack(sum_r_q);
    end
  end

`ifdef MIXER_PEAK_HOLD_EN
  logic xfer;
  assign xfer = m_valid && m_ready;

  // The most negative code has no positive twin, so its magnitude is pinned to full scale.
  function automatic logic [SIZE-2:0] peak_mag(input logic [SIZE-1:0] x);
    logic [SIZE-1:0] n;
    n = -x;
    if (!x[SIZE-1]) return x[SIZE-2:0];
    if (n[SIZE-1]) return '1;
    return n[SIZE-2:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_left_out  <= '0;
      peak_right_out <= '0;
    end else if (peak_clear) begin
      peak_left_out  <= xfer ? peak_mag(audio_mixed_left_out) : '0;
      peak_right_out <= xfer ? peak_mag(audio_mixed_right_out) : '0;
    end else if (xfer) begin
      if (peak_mag(audio_mixed_left_out) > peak_left_out)
        peak_left_out <= peak_mag(audio_mixed_left_out);
      if (peak_mag(audio_mixed_right_out) > peak_right_out)
        peak_right_out <= peak_mag(audio_mixed_right_out);
    end
  end
`endif

endmodule

// File: doc/audio_mixer_nch.md
Name: audio_mixer_nch

Overview:
Parametrised, pipelined N-channel stereo mixer. It is the sequential successor of the two-channel combinational adder.
- Per-channel gain and mute.
- Widened internal sum with saturation back to SIZE, plus clip flags.
- valid/ready handshake on both sides.
- Sits between the per-stream decoders/jitter buffers and the codec output path.

Parameters:
- SIZE, 24, sample width; signed two's complement.
- NUM_CH, 4, number of stereo input channels (2..16).
- GAIN_W, 16, gain width; unsigned Q1.(GAIN_W-1), where 2^(GAIN_W-1) = unity.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input sample set valid
- s_ready  out  1  mixer can accept
- audio_left_in  in  NUM_CH*SIZE  channel k at [k*SIZE +: SIZE]
- audio_right_in  in  NUM_CH*SIZE  same packing as left
- mute_in  in  NUM_CH  per-channel mute, sampled at accept
- gain_in  in  NUM_CH*GAIN_W  new gains, channel k at [k*GAIN_W +: GAIN_W]
- gain_load  in  1  load gain_in into gain registers
- m_valid  out  1  mixed sample valid
- m_ready  in  1  downstream accepts
- audio_mixed_left_out  out  SIZE  saturated left mix
- audio_mixed_right_out  out  SIZE  saturated right mix
- clip_left_out  out  1  left result was saturated this sample
- clip_right_out  out  1  right result was saturated this sample

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: s_ready=1 from the first cycle after rst deasserts; m_valid=0; data and clip outputs = 0; all gain registers = unity (2^(GAIN_W-1)); all stage valid bits cleared.
- Pipeline: 3 stages, all advancing on a common enable, en = !m_valid | m_ready. s_ready = en. An input is accepted when s_valid & s_ready.
  - S1 multiply: p = sample * gain, with gain zero-extended. The product is arithmetically shifted right by GAIN_W-1, i.e. floor rounding. Result width is SIZE+1. A muted channel contributes 0.
  - S2 sum: signed sum over NUM_CH, width SIZE+1+$clog2(NUM_CH). The sum never overflows internally.
  - S3 saturate: clamp to [-2^(SIZE-1), 2^(SIZE-1)-1] and set the clip flag when clamping occurs. Output registers are written here.
- Latency: exactly 3 cycles from accept to m_valid with m_ready held high. Throughput is 1 sample/cycle.
- Stall: while m_valid & !m_ready, every stage holds its contents and outputs stay stable. No sample is dropped or duplicated. Order is preserved.
- Bubbles: a stage whose valid bit is 0 is still overwritten when en=1, so bubbles propagate.
- Gain load:
  - gain_load=1 updates all gain registers at the clock edge, regardless of en.
  - A sample accepted in the same cycle as gain_load uses the OLD gains. Later samples use the new ones.
  - Mute is sampled with the data at accept, so there is no retroactive effect on samples in flight.
- Reset mid-operation: in-flight samples are discarded and m_valid=0 on the cycle after rst. Gains return to unity.
- Left and right channels are independent datapaths with identical arithmetic.

Optional Feature:
- Macro: MIXER_PEAK_HOLD_EN.
- When defined:
  - Adds input peak_clear (1) and outputs peak_left_out and peak_right_out (SIZE-1 each).
  - Each peak register holds the max |saturated output| over the transferred samples (m_valid & m_ready). |-2^(SIZE-1)| is clamped to 2^(SIZE-1)-1.
  - peak_clear zeroes the register. If a transfer occurs in the same cycle as peak_clear, the register loads that sample's magnitude.
  - Peak registers reset to 0.
- When undefined: the ports and registers do not exist. The datapath is identical either way.

Decomposition:
- Package mixer_pkg holds:
  - unity-gain constant function, sum-width function, clog2 helper;
  - saturate function returning value and clip flag;
  - channel-slice helper functions.
- Sub-module mixer_gain_mult: one channel's stereo S1 stage (two multiplies, shift, mute). Instantiated NUM_CH times in a generate loop. The sum, saturation and handshake stay in the top level.

Test Plan:
All scenarios use SIZE=24, NUM_CH=4, GAIN_W=16 unless stated.
1. Reset, unity gains: ch0L=0x000100, ch1L=0x000200, others 0, single accept → audio_mixed_left_out=0x000300 exactly 3 cycles later, clip_left_out=0, m_valid for exactly one cycle.
2. Saturation: all four left inputs 0x7FFFFF → 0x7FFFFF with clip_left_out=1. All four 0x800000 → 0x800000 with clip_left_out=1. Right channel at 0 gives clip_right_out=0.
3. Gain and rounding: gain_load with ch0 gain 0x4000. Next sample ch0L=0x000100 → 0x000080. ch0L=0xFFFEFF (-257) → 0xFFFF7F (-129, floor). A sample accepted in the gain_load cycle still yields the unity result.
4. Backpressure: stream 6 consecutive samples (values 1..6 on ch0L), m_ready=0 for 5 cycles after the first output → outputs 1..6 in order, no loss, output stable while stalled, s_ready=0 while m_valid & !m_ready.
5. Mute: mute_in=4'b0010 with ch0L=0x000010, ch1L=0x000020 → 0x000010.
6. Reset mid-stream: rst asserted with 3 samples in flight → m_valid=0 next cycle, none of those samples ever appear. With MIXER_PEAK_HOLD_EN defined, the peak registers read 0 after reset.
